// File: rtl/divider_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | divider_pkg : shared widths and result record for the divider    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package divider_pkg;

   localparam int c_div_width_def = 8;
   localparam int c_depth_def     = 4;

   typedef struct packed {
      logic [c_div_width_def-1:0] quotient;
      logic [c_div_width_def-1:0] remainder;
   } div_result_t;

endpackage
`default_nettype wire

// File: rtl/divider_result_mem.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | divider_result_mem : DEPTH x 2*DIV_WIDTH storage, sync write,    |
// | async read, no reset.  Rev 1.0                                   |
// +-----------------------------------------------------------------+
module divider_result_mem
   import divider_pkg::*;
#(
   parameter int DIV_WIDTH = c_div_width_def,
   parameter int DEPTH     = c_depth_def
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [2*DIV_WIDTH-1:0]     wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [2*DIV_WIDTH-1:0]     rd_data
);

   logic [2*DIV_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/divider_result_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | divider_result_fifo : FWFT result queue behind the divider with  |
// | in-flight start throttling. Option: DIVRES_STATUS_EN. Rev 1.0    |
// +-----------------------------------------------------------------+
module divider_result_fifo
   import divider_pkg::*;
#(
   parameter int DIV_WIDTH = c_div_width_def,
   parameter int DEPTH     = c_depth_def
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ld_rem_quotient,
   input  logic [DIV_WIDTH-1:0]          quotient_in,
   input  logic [DIV_WIDTH-1:0]          remainder_in,
   input  logic                          start_seen,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [DIV_WIDTH-1:0]          quotient_out,
   output logic [DIV_WIDTH-1:0]          remainder_out,
   output logic                          full,
   output logic                          start_allow
`ifdef DIVRES_STATUS_EN
   ,
   output logic                          overflow,
   output logic [$clog2(DEPTH):0]        level
`endif
);

   localparam int                 c_ptr_w = $clog2(DEPTH);
   localparam int                 c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   logic [c_ptr_w-1:0]     r_wr_ptr;
   logic [c_ptr_w-1:0]     r_rd_ptr;
   logic [c_cnt_w-1:0]     r_count;
   logic                   r_pending;
   logic                   w_valid;
   logic                   w_full;
   logic                   w_push;
   logic                   w_pop;
   logic [2*DIV_WIDTH-1:0] w_rd_data;

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == c_depth);
   assign w_pop   = w_valid & out_ready;
   // A full queue still accepts a push when the head leaves on the same edge.
   assign w_push  = ld_rem_quotient & (~w_full | w_pop);

   divider_result_mem #(
      .DIV_WIDTH (DIV_WIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_push & ~rst),
      .wr_addr (r_wr_ptr),
      .wr_data ({quotient_in, remainder_in}),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_pending <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_cnt_w'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_cnt_w'(1);
         end
         // A new start on the completing push's edge is the next division in flight.
         if (start_seen) begin
            r_pending <= 1'b1;
         end else if (w_push) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign out_valid     = w_valid;
   assign full          = w_full;
   assign quotient_out  = w_valid ? w_rd_data[2*DIV_WIDTH-1:DIV_WIDTH] : '0;
   assign remainder_out = w_valid ? w_rd_data[DIV_WIDTH-1:0] : '0;
   assign start_allow   = ((r_count + c_cnt_w'(r_pending)) < c_depth);

`ifdef DIVRES_STATUS_EN
   logic r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (ld_rem_quotient && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
   assign level    = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_divider_result_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_divider_result_fifo : directed self-checking bench.  Rev 1.0  |
// +-----------------------------------------------------------------+
module tb_divider_result_fifo;

   localparam int DW = 8;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_rem_quotient;
   logic [DW-1:0] quotient_in;
   logic [DW-1:0] remainder_in;
   logic          start_seen;
   logic          out_ready;
   logic          out_valid;
   logic [DW-1:0] quotient_out;
   logic [DW-1:0] remainder_out;
   logic          full;
   logic          start_allow;
`ifdef DIVRES_STATUS_EN
   logic          overflow;
   logic [2:0]    level;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   divider_result_fifo #(
      .DIV_WIDTH (DW),
      .DEPTH     (DP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ld_rem_quotient (ld_rem_quotient),
      .quotient_in     (quotient_in),
      .remainder_in    (remainder_in),
      .start_seen      (start_seen),
      .out_ready       (out_ready),
      .out_valid       (out_valid),
      .quotient_out    (quotient_out),
      .remainder_out   (remainder_out),
      .full            (full),
      .start_allow     (start_allow)
`ifdef DIVRES_STATUS_EN
      ,
      .overflow        (overflow),
      .level           (level)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_hold(input int q, input int r);
      ld_rem_quotient = 1'b1;
      quotient_in     = DW'(q);
      remainder_in    = DW'(r);
      tick();
      ld_rem_quotient = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      ld_rem_quotient = 1'b0;
      quotient_in     = '0;
      remainder_in    = '0;
      start_seen      = 1'b0;
      out_ready       = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check_eq("rst_valid", 32'(out_valid), 0);
      check_eq("rst_full", 32'(full), 0);
      check_eq("rst_start_allow", 32'(start_allow), 1);
      check_eq("rst_quot", 32'(quotient_out), 0);
      check_eq("rst_rem", 32'(remainder_out), 0);

      // 13/4 = 3 rem 1, consumer always ready
      out_ready = 1'b1;
      push_hold(3, 1);
      check_eq("single_valid", 32'(out_valid), 1);
      check_eq("single_quot", 32'(quotient_out), 3);
      check_eq("single_rem", 32'(remainder_out), 1);
      tick();
      check_eq("single_popped", 32'(out_valid), 0);
      check_eq("single_zero_quot", 32'(quotient_out), 0);

      // five pushes into a 4-deep queue with a stalled consumer
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         push_hold(i, i + 16);
         if (i == 4) check_eq("full_after_4", 32'(full), 1);
      end
      check_eq("full_after_5", 32'(full), 1);
`ifdef DIVRES_STATUS_EN
      check_eq("overflow_set", 32'(overflow), 1);
      check_eq("level_full", 32'(level), 4);
`endif
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check_eq("drain_quot", 32'(quotient_out), 32'(i));
         check_eq("drain_rem", 32'(remainder_out), 32'(i + 16));
         tick();
      end
      check_eq("drain_empty", 32'(out_valid), 0);

      // push and pop on the same edge while full
      out_ready = 1'b0;
      for (int i = 5; i <= 8; i++) push_hold(i, 0);
      out_ready = 1'b1;
      push_hold(9, 2);
      check_eq("fullpp_full", 32'(full), 1);
      for (int i = 6; i <= 9; i++) begin
         check_eq("fullpp_order", 32'(quotient_out), 32'(i));
         tick();
      end
      check_eq("fullpp_empty", 32'(out_valid), 0);

      // ten simultaneous push/pop cycles, pointers wrap
      out_ready = 1'b0;
      push_hold(100, 0);
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         ld_rem_quotient = 1'b1;
         quotient_in     = DW'(100 + i);
         check_eq("wrap_head", 32'(quotient_out), 32'(100 + i - 1));
         tick();
      end
      ld_rem_quotient = 1'b0;
      check_eq("wrap_last", 32'(quotient_out), 110);
      check_eq("wrap_not_full", 32'(full), 0);
      tick();
      check_eq("wrap_empty", 32'(out_valid), 0);

      // reset with two entries stored and a push on the reset edge
      out_ready = 1'b0;
      push_hold(11, 1);
      push_hold(12, 2);
      rst             = 1'b1;
      ld_rem_quotient = 1'b1;
      quotient_in     = 8'd13;
      tick();
      rst             = 1'b0;
      ld_rem_quotient = 1'b0;
      check_eq("mrst_valid", 32'(out_valid), 0);
      check_eq("mrst_quot", 32'(quotient_out), 0);
      check_eq("mrst_rem", 32'(remainder_out), 0);
`ifdef DIVRES_STATUS_EN
      check_eq("mrst_level", 32'(level), 0);
      check_eq("mrst_overflow", 32'(overflow), 0);
`endif
      tick();
      check_eq("mrst_push_ignored", 32'(out_valid), 0);

      // start throttling at occupancy DEPTH-1
      for (int i = 1; i <= 3; i++) push_hold(20 + i, 0);
      check_eq("thr_allow_before", 32'(start_allow), 1);
      start_seen = 1'b1;
      tick();
      start_seen = 1'b0;
      check_eq("thr_allow_pending", 32'(start_allow), 0);
      tick();
      check_eq("thr_allow_hold", 32'(start_allow), 0);
      push_hold(42, 0);
      check_eq("thr_full", 32'(full), 1);
      check_eq("thr_allow_full", 32'(start_allow), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("thr_allow_after_pop", 32'(start_allow), 1);
      check_eq("thr_head_after_pop", 32'(quotient_out), 22);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
